// File: rtl/time_sync_phc_wr_arb.sv
`default_nettype none
// ============================================================================
// time_sync_phc_wr_arb : round-robin sharing of the PHC ToD write port among
//                        IF_COUNT time-sync slaves, with ack timeout/hold-off
// Revision 1.0
// ============================================================================
module time_sync_phc_wr_arb #(
  parameter int IF_COUNT       = 2,
  parameter int ACK_TIMEOUT    = 1024,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int CNT_WIDTH      = 16,
  localparam int IDX_W         = (IF_COUNT > 1) ? $clog2(IF_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IF_COUNT-1:0]    sync_wr_en,
  input  logic [IF_COUNT*96-1:0] sync_wr_ts,
  output logic                   time_sync_wr_en,
  output logic [29:0]            time_sync_wr_ns,
  output logic [47:0]            time_sync_wr_s,
  input  logic                   time_sync_wr_ack,
  output logic                   busy,
  output logic [IDX_W-1:0]       last_grant,
  output logic [CNT_WIDTH-1:0]   overwrite_count,
  output logic [CNT_WIDTH-1:0]   invalid_count,
  output logic [CNT_WIDTH-1:0]   timeout_count
);
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int HO_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [31:0]      NS_LIMIT = 32'd1_000_000_000;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [IDX_W:0]   IF_CNT   = (IDX_W+1)'(IF_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 wr_en_q, wr_en_d;
  logic [29:0]          wr_ns_q, wr_ns_d;
  logic [47:0]          wr_s_q, wr_s_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [HO_W-1:0]      ho_q, ho_d;
  logic [IF_COUNT-1:0]  pend_valid_q, pend_valid_d;
  logic [47:0]          slot_s_q [IF_COUNT];
  logic [47:0]          slot_s_d [IF_COUNT];
  logic [29:0]          slot_ns_q [IF_COUNT];
  logic [29:0]          slot_ns_d [IF_COUNT];
  logic [CNT_WIDTH-1:0] ov_cnt_q, ov_cnt_d;
  logic [CNT_WIDTH-1:0] inv_cnt_q, inv_cnt_d;
  logic [CNT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W:0]       cand;
  logic [IDX_W:0]       rr_next;

  always_comb begin
    state_d      = state_q;
    wr_en_d      = wr_en_q;
    wr_ns_d      = wr_ns_q;
    wr_s_d       = wr_s_q;
    last_grant_d = last_grant_q;
    rr_ptr_d     = rr_ptr_q;
    tmo_d        = tmo_q;
    ho_d         = ho_q;
    pend_valid_d = pend_valid_q;
    slot_s_d     = slot_s_q;
    slot_ns_d    = slot_ns_q;
    ov_cnt_d     = ov_cnt_q;
    inv_cnt_d    = inv_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    grant_found  = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    rr_next      = '0;

    // Descending scan so the candidate closest to rr_ptr is the one kept.
    for (int k = IF_COUNT - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= IF_CNT) cand = cand - IF_CNT;
      if (pend_valid_q[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          wr_en_d                 = 1'b1;
          wr_s_d                  = slot_s_q[grant_idx];
          wr_ns_d                 = slot_ns_q[grant_idx];
          pend_valid_d[grant_idx] = 1'b0;
          last_grant_d            = grant_idx;
          rr_next                 = {1'b0, grant_idx} + (IDX_W+1)'(1);
          if (rr_next == IF_CNT) rr_next = '0;
          rr_ptr_d                = rr_next[IDX_W-1:0];
          tmo_d                   = '0;
          state_d                 = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (time_sync_wr_ack || tmo_q == TMO_LAST) begin
          wr_en_d = 1'b0;
          ho_d    = '0;
          state_d = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
          if (!time_sync_wr_ack && tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + CNT_WIDTH'(1);
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (ho_q == HO_LAST) state_d = ST_IDLE;
        else                 ho_d    = ho_q + HO_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request on a slot being granted this edge sees the slot as free.
    for (int i = 0; i < IF_COUNT; i++) begin
      if (sync_wr_en[i]) begin
        if (sync_wr_ts[i*96+16 +: 32] < NS_LIMIT) begin
          if (pend_valid_d[i] && ov_cnt_d != '1) ov_cnt_d = ov_cnt_d + CNT_WIDTH'(1);
          pend_valid_d[i] = 1'b1;
          slot_s_d[i]     = sync_wr_ts[i*96+48 +: 48];
          slot_ns_d[i]    = sync_wr_ts[i*96+16 +: 30];
        end else if (inv_cnt_d != '1) begin
          inv_cnt_d = inv_cnt_d + CNT_WIDTH'(1);
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_en_q      <= 1'b0;
      wr_ns_q      <= '0;
      wr_s_q       <= '0;
      busy_q       <= 1'b0;
      last_grant_q <= '0;
      rr_ptr_q     <= '0;
      tmo_q        <= '0;
      ho_q         <= '0;
      pend_valid_q <= '0;
      ov_cnt_q     <= '0;
      inv_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      for (int i = 0; i < IF_COUNT; i++) begin
        slot_s_q[i]  <= '0;
        slot_ns_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_ns_q      <= wr_ns_d;
      wr_s_q       <= wr_s_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      rr_ptr_q     <= rr_ptr_d;
      tmo_q        <= tmo_d;
      ho_q         <= ho_d;
      pend_valid_q <= pend_valid_d;
      ov_cnt_q     <= ov_cnt_d;
      inv_cnt_q    <= inv_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      slot_s_q     <= slot_s_d;
      slot_ns_q    <= slot_ns_d;
    end
  end

  assign time_sync_wr_en = wr_en_q;
  assign time_sync_wr_ns = wr_ns_q;
  assign time_sync_wr_s  = wr_s_q;
  assign busy            = busy_q;
  assign last_grant      = last_grant_q;
  assign overwrite_count = ov_cnt_q;
  assign invalid_count   = inv_cnt_q;
  assign timeout_count   = tmo_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_time_sync_phc_wr_arb.sv
`default_nettype none
// Directed bench for time_sync_phc_wr_arb: instance a has a long ack timeout,
// instance b an 8-cycle timeout with its ack tied low.
module tb_time_sync_phc_wr_arb;
  localparam int N  = 2;
  localparam int HO = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [N-1:0]    a_req = '0, b_req = '0;
  logic [N*96-1:0] a_ts = '0, b_ts = '0;
  logic            a_ack = 1'b0;
  logic            b_ack = 1'b0;
  logic            a_wr_en, b_wr_en, a_busy, b_busy;
  logic [29:0]     a_ns, b_ns;
  logic [47:0]     a_s, b_s;
  logic [0:0]      a_lg, b_lg;
  logic [CW-1:0]   a_ov, a_inv, a_tmo, b_ov, b_inv, b_tmo;

  time_sync_phc_wr_arb #(.IF_COUNT(N), .ACK_TIMEOUT(1024), .HOLDOFF_CYCLES(HO), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .rst(rst), .sync_wr_en(a_req), .sync_wr_ts(a_ts),
    .time_sync_wr_en(a_wr_en), .time_sync_wr_ns(a_ns), .time_sync_wr_s(a_s),
    .time_sync_wr_ack(a_ack), .busy(a_busy), .last_grant(a_lg),
    .overwrite_count(a_ov), .invalid_count(a_inv), .timeout_count(a_tmo));

  time_sync_phc_wr_arb #(.IF_COUNT(N), .ACK_TIMEOUT(8), .HOLDOFF_CYCLES(HO), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst(rst), .sync_wr_en(b_req), .sync_wr_ts(b_ts),
    .time_sync_wr_en(b_wr_en), .time_sync_wr_ns(b_ns), .time_sync_wr_s(b_s),
    .time_sync_wr_ack(b_ack), .busy(b_busy), .last_grant(b_lg),
    .overwrite_count(b_ov), .invalid_count(b_inv), .timeout_count(b_tmo));

  function automatic logic [95:0] mk_ts(input logic [47:0] s, input logic [31:0] ns);
    return {s, ns, 16'hBEEF};
  endfunction

  function automatic logic wr_of(input bit b);
    return b ? b_wr_en : a_wr_en;
  endfunction

  task automatic do_reset();
    rst = 1'b1; a_req = '0; b_req = '0; a_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe(input bit b, input logic [N-1:0] m, input logic [95:0] t0, input logic [95:0] t1);
    if (b) begin b_req = m; b_ts = {t1, t0}; end
    else   begin a_req = m; a_ts = {t1, t0}; end
    @(negedge clk);
    a_req = '0; b_req = '0;
  endtask

  task automatic wait_wr(input bit b, input int bound, output int waited);
    waited = 0;
    while (wr_of(b) !== 1'b1 && waited < bound) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Called in the first wr_en cycle; acks in cycle k and reports cycles high.
  task automatic ack_in(input int k, output int high);
    high = 0;
    for (int c = 1; c <= k; c++) begin
      if (a_wr_en === 1'b1) high++;
      a_ack = (c == k);
      @(negedge clk);
    end
    a_ack = 1'b0;
    while (a_wr_en === 1'b1 && high < 2000) begin
      high++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (a_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %0b want 0", a_wr_en); end
    tests++; if (a_ns !== 30'd0) begin fails++; $display("FAIL reset_ns: got %0d want 0", a_ns); end
    tests++; if (a_s !== 48'd0) begin fails++; $display("FAIL reset_s: got %0h want 0", a_s); end
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", a_busy); end
    tests++; if (a_lg !== 1'b0) begin fails++; $display("FAIL reset_last_grant: got %0d want 0", a_lg); end
    tests++; if ({a_ov, a_inv, a_tmo} !== '0) begin fails++; $display("FAIL reset_counters: got %0h/%0h/%0h want 0", a_ov, a_inv, a_tmo); end
    tests++; if (b_wr_en !== 1'b0) begin fails++; $display("FAIL reset_b_wr_en: got %0b want 0", b_wr_en); end
  endtask

  task automatic test_single();
    int hi;
    do_reset();
    strobe(0, 2'b01, mk_ts(48'h1234, 32'd500), '0);
    tests++; if (a_wr_en !== 1'b0) begin fails++; $display("FAIL single_early: wr_en got %0b want 0", a_wr_en); end
    @(negedge clk);
    tests++; if (a_wr_en !== 1'b1) begin fails++; $display("FAIL single_rise: wr_en got %0b want 1", a_wr_en); end
    tests++; if (a_s !== 48'h1234) begin fails++; $display("FAIL single_s: got %0h want 1234", a_s); end
    tests++; if (a_ns !== 30'd500) begin fails++; $display("FAIL single_ns: got %0d want 500", a_ns); end
    tests++; if (a_lg !== 1'b0) begin fails++; $display("FAIL single_grant: got %0d want 0", a_lg); end
    ack_in(2, hi);
    tests++; if (hi != 2) begin fails++; $display("FAIL single_len: wr_en high %0d cycles want 2", hi); end
    tests++; if (a_busy !== 1'b1) begin fails++; $display("FAIL single_busy_hold0: got %0b want 1", a_busy); end
    repeat (3) @(negedge clk);
    tests++; if (a_busy !== 1'b1) begin fails++; $display("FAIL single_busy_hold3: got %0b want 1", a_busy); end
    @(negedge clk);
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL single_busy_clear: got %0b want 0", a_busy); end
  endtask

  task automatic test_round_robin();
    int w, hi, prev;
    bit have_prev;
    logic [29:0] exp_ns;
    logic [0:0]  exp_g;
    do_reset();
    have_prev = 1'b0;
    prev = 0;
    for (int r = 0; r < 3; r++) begin
      strobe(0, 2'b11, mk_ts(48'h100 + 48'(r), 32'd1000 + 32'(r)), mk_ts(48'h200 + 48'(r), 32'd2000 + 32'(r)));
      for (int g = 0; g < 2; g++) begin
        exp_g  = 1'(g);
        exp_ns = (g == 0) ? 30'(1000 + r) : 30'(2000 + r);
        wait_wr(0, 20, w);
        tests++; if (w >= 20) begin fails++; $display("FAIL rr_wait r%0d g%0d: no wr_en within %0d cycles", r, g, w); end
        tests++; if (a_lg !== exp_g) begin fails++; $display("FAIL rr_grant r%0d: got %0d want %0d", r, a_lg, exp_g); end
        tests++; if (a_ns !== exp_ns) begin fails++; $display("FAIL rr_ns r%0d: got %0d want %0d", r, a_ns, exp_ns); end
        if (have_prev) begin
          tests++; if (cyc - prev < HO + 2) begin fails++; $display("FAIL rr_spacing r%0d: got %0d want >=%0d", r, cyc - prev, HO + 2); end
        end
        have_prev = 1'b1;
        prev = cyc;
        ack_in(1, hi);
        tests++; if (hi != 1) begin fails++; $display("FAIL rr_len r%0d: high %0d want 1", r, hi); end
      end
    end
  endtask

  task automatic test_overwrite();
    int w, hi;
    do_reset();
    strobe(0, 2'b01, mk_ts(48'h1, 32'd100), '0);
    wait_wr(0, 10, w);
    tests++; if (w >= 10) begin fails++; $display("FAIL ow_first_wait: no wr_en within %0d cycles", w); end
    strobe(0, 2'b10, '0, mk_ts(48'h7, 32'd10));
    strobe(0, 2'b10, '0, mk_ts(48'h8, 32'd20));
    tests++; if (a_ov !== 16'd1) begin fails++; $display("FAIL ow_count: got %0d want 1", a_ov); end
    ack_in(1, hi);
    wait_wr(0, 20, w);
    tests++; if (w >= 20) begin fails++; $display("FAIL ow_second_wait: no wr_en within %0d cycles", w); end
    tests++; if (a_lg !== 1'b1) begin fails++; $display("FAIL ow_grant: got %0d want 1", a_lg); end
    tests++; if (a_ns !== 30'd20 || a_s !== 48'h8) begin fails++; $display("FAIL ow_data: got s=%0h ns=%0d want s=8 ns=20", a_s, a_ns); end
    ack_in(1, hi);
    tests++; if (a_ov !== 16'd1) begin fails++; $display("FAIL ow_count_after: got %0d want 1", a_ov); end
  endtask

  task automatic test_invalid();
    int w, hi;
    do_reset();
    strobe(0, 2'b01, mk_ts(48'h9, 32'd1_000_000_000), '0);
    wait_wr(0, 10, w);
    tests++; if (w != 10) begin fails++; $display("FAIL inv_no_write: wr_en after %0d cycles want none", w); end
    tests++; if (a_inv !== 16'd1) begin fails++; $display("FAIL inv_count: got %0d want 1", a_inv); end
    strobe(0, 2'b10, '0, mk_ts(48'h5, 32'd55));
    wait_wr(0, 10, w);
    tests++; if (w >= 10) begin fails++; $display("FAIL inv_s1_wait: no wr_en within %0d cycles", w); end
    strobe(0, 2'b01, mk_ts(48'h3, 32'd300), '0);
    strobe(0, 2'b01, mk_ts(48'h9, 32'd1_000_000_005), '0);
    tests++; if (a_inv !== 16'd2 || a_ov !== 16'd0) begin fails++; $display("FAIL inv_counts: got inv=%0d ov=%0d want 2/0", a_inv, a_ov); end
    ack_in(1, hi);
    wait_wr(0, 20, w);
    tests++; if (w >= 20) begin fails++; $display("FAIL inv_slot_wait: no wr_en within %0d cycles", w); end
    tests++; if (a_s !== 48'h3 || a_ns !== 30'd300 || a_lg !== 1'b0) begin fails++; $display("FAIL inv_slot_kept: got s=%0h ns=%0d g=%0d want s=3 ns=300 g=0", a_s, a_ns, a_lg); end
    ack_in(1, hi);
  endtask

  task automatic test_timeout();
    int w, hi;
    do_reset();
    strobe(1, 2'b01, mk_ts(48'hAB, 32'd77), '0);
    wait_wr(1, 10, w);
    tests++; if (w >= 10) begin fails++; $display("FAIL to_wait: no wr_en within %0d cycles", w); end
    tests++; if (b_s !== 48'hAB || b_ns !== 30'd77) begin fails++; $display("FAIL to_data: got s=%0h ns=%0d want s=ab ns=77", b_s, b_ns); end
    hi = 0;
    while (b_wr_en === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    tests++; if (hi != 8) begin fails++; $display("FAIL to_len: wr_en high %0d cycles want 8", hi); end
    tests++; if (b_tmo !== 16'd1) begin fails++; $display("FAIL to_count: got %0d want 1", b_tmo); end
    wait_wr(1, 30, w);
    tests++; if (w != 30) begin fails++; $display("FAIL to_reissue: wr_en after %0d cycles want none", w); end
    tests++; if (b_busy !== 1'b0 || b_tmo !== 16'd1) begin fails++; $display("FAIL to_final: busy=%0b tmo=%0d want 0/1", b_busy, b_tmo); end
  endtask

  task automatic test_reset_mid_issue();
    int w;
    do_reset();
    strobe(0, 2'b11, mk_ts(48'h55, 32'd5), mk_ts(48'h66, 32'd6));
    wait_wr(0, 10, w);
    tests++; if (w >= 10) begin fails++; $display("FAIL rmi_wait: no wr_en within %0d cycles", w); end
    strobe(0, 2'b10, '0, mk_ts(48'h77, 32'd7));
    tests++; if (a_wr_en !== 1'b1 || a_ov !== 16'd1) begin fails++; $display("FAIL rmi_pre: wr_en=%0b ov=%0d want 1/1", a_wr_en, a_ov); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (a_wr_en !== 1'b0) begin fails++; $display("FAIL rmi_wr_en: got %0b want 0", a_wr_en); end
    tests++; if (a_busy !== 1'b0 || {a_ov, a_inv, a_tmo} !== '0) begin fails++; $display("FAIL rmi_state: busy=%0b ov=%0d inv=%0d tmo=%0d want 0", a_busy, a_ov, a_inv, a_tmo); end
    rst = 1'b0;
    wait_wr(0, 20, w);
    tests++; if (w != 20) begin fails++; $display("FAIL rmi_no_write: wr_en after %0d cycles want none", w); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overwrite();
    test_invalid();
    test_timeout();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/time_sync_phc_wr_arb.md
# time_sync_phc_wr_arb

Round-robin arbiter and sequencer that shares the single PTP hardware clock (PHC) write port among `IF_COUNT` time-sync slave instances. Each slave posts a 96-bit ToD correction pulse. The block holds one pending correction per slave, validates it, and issues it on the PHC write handshake. It enforces an acknowledge timeout and a minimum hold-off between successive PHC writes. It sits in the core clock domain between the per-interface slaves and the PHC register write interface.

## Interface
Parameters:
- `IF_COUNT`, 2: number of requesting slaves (≥1).
- `ACK_TIMEOUT`, 1024: max cycles `time_sync_wr_en` stays high awaiting ack (≥1).
- `HOLDOFF_CYCLES`, 64: idle cycles enforced after each completed or aborted write (≥0).
- `CNT_WIDTH`, 16: width of saturating status counters.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: core clock.
- `rst` in 1: synchronous active-high reset.
- `sync_wr_en` in `IF_COUNT`: per-slave single-cycle request strobe.
- `sync_wr_ts` in `IF_COUNT*96`: per-slave ToD; `[95:48]` s, `[47:16]` ns, `[15:0]` fractional ns (ignored).
- `time_sync_wr_en` out 1: PHC write request, held until ack or timeout.
- `time_sync_wr_ns` out 30: ns value, `ts[45:16]`.
- `time_sync_wr_s` out 48: seconds, `ts[95:48]`.
- `time_sync_wr_ack` in 1: PHC write accepted.
- `busy` out 1: FSM not in IDLE.
- `last_grant` out `$clog2(IF_COUNT)` (min 1): index of the most recently issued requester.
- `overwrite_count` out `CNT_WIDTH`: pending corrections replaced before issue.
- `invalid_count` out `CNT_WIDTH`: requests rejected because ns ≥ 1 000 000 000.
- `timeout_count` out `CNT_WIDTH`: writes aborted by timeout.

## Operation
- Per-slave pending slot: `pend_valid[i]` and `pend_ts[i]`.
  - On `sync_wr_en[i]` with `ts[47:16] < 1e9`, the slot loads and the valid bit sets.
  - If the slot was already valid, `overwrite_count` increments (newest wins).
  - If ns is invalid, the slot is untouched and `invalid_count` increments.
- FSM states: IDLE, ISSUE, HOLDOFF.
  - **IDLE:** if any `pend_valid`, pick the first valid index searching from `rr_ptr` upward with wrap. On that edge:
    - load `wr_s`/`wr_ns` from the slot and assert `time_sync_wr_en`;
    - clear `pend_valid[g]`, set `last_grant=g`, set `rr_ptr=(g+1) mod IF_COUNT`;
    - clear the timeout counter and go to ISSUE.
  - **ISSUE:** `time_sync_wr_en`=1 with data stable.
    - On `time_sync_wr_ack`: deassert `wr_en` next edge and go to HOLDOFF.
    - Otherwise the timeout counter increments each cycle. When it reaches `ACK_TIMEOUT`, deassert `wr_en`, increment `timeout_count`, go to HOLDOFF. The aborted value is discarded, not re-queued.
  - **HOLDOFF:** count `HOLDOFF_CYCLES` cycles, then go to IDLE. If `HOLDOFF_CYCLES`=0, go directly to IDLE on the next edge.
- Requests are accepted into slots in every state.
- Simultaneous grant-clear and new request on the same slot: the set wins, the slot holds the new value, and `overwrite_count` does not increment.
- Counters saturate at all-ones. Multiple counter events in one cycle on different slots: add the count of events (saturating).
- `ts[15:0]` and `ts[47:46]` are never driven out.

## Timing
- Reset values:
  - `time_sync_wr_en`=0, `wr_ns`=0, `wr_s`=0, `busy`=0, `last_grant`=0, all counters 0;
  - `rr_ptr`=0, all `pend_valid`=0, FSM=IDLE.
- Reset mid-ISSUE: `wr_en` drops in the cycle after the reset edge; pending slots are lost.
- Latency:
  - request sampled at edge E0 → `pend_valid` set after E0;
  - `time_sync_wr_en` high after E1 (2 edges) when IDLE and no contention.
- Ack may arrive in the first `wr_en` cycle.
- `wr_en` is high for exactly k cycles for an ack in the k-th cycle, or `ACK_TIMEOUT` cycles on timeout.
- Ack outside ISSUE is ignored.
- Minimum spacing between rising edges of `wr_en` is 1 (ISSUE) + `HOLDOFF_CYCLES` + 1 (IDLE) cycles.
- `busy`, `last_grant`, and the counters are registered and update on the edge that causes them.

## Test plan
- **Single request:** with `IF_COUNT`=2, `HOLDOFF_CYCLES`=4, slave 0 requests s=0x1234, ns=500; ack one cycle after `wr_en` rises.
  - `wr_en` rises 2 edges after the strobe and lasts 2 cycles.
  - `wr_s`=0x1234, `wr_ns`=500, `last_grant`=0.
  - `busy` clears 4 cycles after `wr_en` falls.
- **Round robin:** both slaves strobe in the same cycle three times (waiting for completion each time).
  - Issue order is 0,1 (first burst), then 0,1 again, since `rr_ptr` returns to 0.
  - Each write is separated by ≥`HOLDOFF_CYCLES`+2 cycles.
- **Overwrite:** hold ack low with `ACK_TIMEOUT`=1024; slave 1 strobes ns=10 then ns=20 while slave 0 is in ISSUE; then ack.
  - Slave 1 issues ns=20.
  - `overwrite_count`=1.
- **Invalid ns:** slave 0 strobes ns=1 000 000 000.
  - No `wr_en`.
  - `invalid_count`=1 and the slot is unchanged.
- **Timeout:** `ACK_TIMEOUT`=8, ack never asserted.
  - `wr_en` is high for exactly 8 cycles.
  - `timeout_count`=1 and the value is not reissued.
- **Reset mid-ISSUE:** pending on slot 1, `rst` pulsed during ISSUE.
  - `wr_en`=0 the next cycle.
  - All counters and pending bits are 0, and no write follows.
